prio_encoder_rr: RTL

- Parametrised, registered N-to-log2(N) priority encoder; successor to the team's fixed 8-to-3 OR-encoder.
- Adds a priority mode: fixed-highest-index or round-robin. Also adds a "no request" flag, a "multiple requests" flag, and a one-deep valid/ready output register with backpressure.
- Sits between request sources (interrupt lines, arbiter requests) and downstream logic that consumes one encoded index per transaction.

---
 rtl/prio_encoder_rr.sv | 107 ++++++++++
 1 files changed

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with fixed or round-robin priority,
// any/multi request flags and a one-deep valid/ready output register.
module prio_encoder_rr #(
    parameter int N       = 8,
    parameter int RR_MODE = 0,
    localparam int W      = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] I,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] Y,
    output logic         any,
    output logic         multi,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] y_q, y_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic         any_q, any_d;
    logic         multi_q, multi_d;
    logic         out_valid_q, out_valid_d;

    logic         accept;
    logic         xfer;
    logic [W-1:0] fix_idx;
    logic [W-1:0] rr_idx;
    logic         rr_found;
    logic [W:0]   rr_pos;
    logic         req_any;
    logic         req_multi;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid_q && out_ready;

    assign req_any   = |I;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign req_multi = |(I & (I - N'(1)));

    // Later iterations overwrite earlier ones, so the highest set index wins.
    always_comb begin
        fix_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (I[i]) fix_idx = W'(i);
        end
    end

    // Walk upward from ptr, wrapping at N-1 (not 2^W-1) so Y stays below N.
    always_comb begin
        rr_idx   = '0;
        rr_found = 1'b0;
        rr_pos   = '0;
        for (int off = 0; off < N; off++) begin
            rr_pos = {1'b0, ptr_q} + (W+1)'(off);
            if (rr_pos >= (W+1)'(N)) rr_pos = rr_pos - (W+1)'(N);
            if (!rr_found && I[rr_pos[W-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = rr_pos[W-1:0];
            end
        end
    end

    // I only reaches the registers through an accept, so idle-time X is blocked.
    always_comb begin
        y_d         = y_q;
        any_d       = any_q;
        multi_d     = multi_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (accept) begin
            y_d         = (RR_MODE != 0) ? rr_idx : fix_idx;
            any_d       = req_any;
            multi_d     = req_multi;
            out_valid_d = 1'b1;
            if (RR_MODE != 0 && req_any) begin
                ptr_d = (rr_idx == W'(N-1)) ? '0 : rr_idx + W'(1);
            end
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q         <= '0;
            any_q       <= 1'b0;
            multi_q     <= 1'b0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            y_q         <= y_d;
            any_q       <= any_d;
            multi_q     <= multi_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign Y         = y_q;
    assign any       = any_q;
    assign multi     = multi_q;
    assign out_valid = out_valid_q;

endmodule
